// File: rtl/i2c_wr_sched.sv
// i2c_wr_sched: round-robin arbiter in front of a byte-level I2C engine.
// Each grant runs one register write ({dev,W}, reg, data), then a STOP,
// then a one-cycle done pulse with a 2-bit status to the granted client.
//
// state | meaning
// IDLE  | no transaction; arbitrate once the engine reports idle
// LOAD  | hand the current byte to the engine (eng_load pulse)
// WAIT  | wait for the byte/ACK completion or the per-byte timeout
// STOP  | ask the engine for a STOP condition
// FIN   | done pulse to the client, status valid, advance round-robin pointer
module i2c_wr_sched #(
  parameter int NREQ    = 4,
  parameter int TO_W    = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_dev,
  input  logic [8*NREQ-1:0] req_reg,
  input  logic [8*NREQ-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [1:0]        err,
  output logic              busy,
  output logic              eng_load,
  output logic [7:0]        eng_data,
  output logic              eng_stop,
  input  logic              eng_byte_done,
  input  logic              eng_nack,
  input  logic              eng_idle
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_STOP, S_FIN} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, rr_ptr, win_idx;
  logic            win_found;
  logic [6:0]      dev_q, win_dev;
  logic [7:0]      reg_q, wd_q, win_reg, win_wd;
  logic [1:0]      byte_idx;
  logic [TO_W-1:0] cnt;
  logic [1:0]      err_q;
  logic            go, to_hit, last_byte;
  int              cand;

  // Round-robin pick: first requester after rr_ptr, wrapping, plus its fields.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_dev   = '0;
    win_reg   = '0;
    win_wd    = '0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(rr_ptr) + k) % NREQ;
      if (!win_found && req[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
        win_dev   = 7'(req_dev >> (7 * cand));
        win_reg   = 8'(req_reg >> (8 * cand));
        win_wd    = 8'(req_wdata >> (8 * cand));
      end
    end
  end

  assign go        = (state == S_IDLE) && win_found && eng_idle;
  assign to_hit    = (cnt == TO_W'(TIMEOUT - 1));
  assign last_byte = (byte_idx == 2'd2);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state decode; a byte completion beats a coincident timeout.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (go) state_nx = S_LOAD;
      S_LOAD: state_nx = S_WAIT;
      S_WAIT: begin
        if (eng_byte_done) begin
          if (eng_nack || last_byte) state_nx = S_STOP;
          else                       state_nx = S_LOAD;
        end else if (to_hit) begin
          state_nx = S_STOP;
        end
      end
      S_STOP: state_nx = S_FIN;
      S_FIN:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Transaction datapath: latched request, byte index, timeout counter, status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      rr_ptr   <= IW'(NREQ - 1);
      dev_q    <= '0;
      reg_q    <= '0;
      wd_q     <= '0;
      byte_idx <= '0;
      cnt      <= '0;
      err_q    <= '0;
    end else begin
      case (state)
        S_IDLE: if (go) begin
          idx      <= win_idx;
          dev_q    <= win_dev;
          reg_q    <= win_reg;
          wd_q     <= win_wd;
          byte_idx <= '0;
          err_q    <= '0;
        end
        S_LOAD: cnt <= '0;
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng_byte_done) begin
            if (eng_nack)        err_q    <= 2'b01;
            else if (!last_byte) byte_idx <= byte_idx + 2'd1;
            else                 err_q    <= 2'b00;
          end else if (to_hit) begin
            err_q <= 2'b10;
          end
        end
        S_FIN: rr_ptr <= idx;
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from state so a reset drops them at once.
  always_comb begin
    gnt      = '0;
    done     = '0;
    eng_load = 1'b0;
    eng_stop = 1'b0;
    busy     = (state != S_IDLE);
    case (state)
      S_LOAD: begin eng_load = 1'b1; gnt[idx] = 1'b1; end
      S_WAIT: gnt[idx] = 1'b1;
      S_STOP: begin eng_stop = 1'b1; gnt[idx] = 1'b1; end
      S_FIN:  begin done[idx] = 1'b1; gnt[idx] = 1'b1; end
      default: ;
    endcase
    case (byte_idx)
      2'd0:    eng_data = {dev_q, 1'b0};
      2'd1:    eng_data = reg_q;
      default: eng_data = wd_q;
    endcase
  end

  assign err = err_q;

endmodule

// File: tb/tb_i2c_wr_sched.sv
// Bench for i2c_wr_sched: transaction-level engine model with randomized
// requests, response delays, NACKs and timeouts, checked against a
// round-robin / write-sequence reference model.
module tb_i2c_wr_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 100;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [27:0]     req_dev;
  logic [31:0]     req_reg, req_wdata;
  logic [3:0]      gnt, done;
  logic [1:0]      err;
  logic            busy, eng_load, eng_stop;
  logic [7:0]      eng_data;
  logic            eng_byte_done, eng_nack, eng_idle;

  int n_chk = 0;
  int n_err = 0;
  int rr_m;
  int act[3];
  int dly[3];

  i2c_wr_sched #(.NREQ(NREQ), .TO_W(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_dev(req_dev), .req_reg(req_reg),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .eng_load(eng_load), .eng_data(eng_data), .eng_stop(eng_stop),
    .eng_byte_done(eng_byte_done), .eng_nack(eng_nack), .eng_idle(eng_idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference arbitration: first set request after the last served client.
  function automatic int pick(input logic [3:0] m, input int p);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return 0;
  endfunction

  // act: 0 = ACK after dly cycles, 1 = NACK after dly cycles, 2 = no response.
  task automatic run_txn(input logic [3:0] mask, input bit mutate);
    int w, n, e_err;
    logic [7:0] eb[3];
    bit fin;
    w = pick(mask, rr_m);
    n = $urandom_range(1, 3);
    eng_idle = 1'b0;
    req = mask;
    repeat (n) begin
      eng_byte_done = 1'($urandom);
      eng_nack = 1'($urandom);
      @(posedge clk); @(negedge clk);
      chk("gnt_while_eng_busy", gnt, 0);
      chk("busy_while_eng_busy", busy, 0);
    end
    eng_byte_done = 1'b0;
    eng_idle = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("gnt_winner", gnt, 1 << w);
    eb[0] = {7'(req_dev >> (7 * w)), 1'b0};
    eb[1] = 8'(req_reg >> (8 * w));
    eb[2] = 8'(req_wdata >> (8 * w));
    if (mutate) begin
      req[w] = 1'b0;
      req_wdata = ~req_wdata;
      req_reg = ~req_reg;
      req_dev = ~req_dev;
    end
    e_err = 0;
    fin = 1'b0;
    for (int b = 0; b < 3 && !fin; b++) begin
      chk("eng_load", eng_load, 1);
      chk("eng_data", eng_data, eb[b]);
      chk("gnt_held", gnt, 1 << w);
      eng_nack = 1'($urandom);
      if (act[b] == 2) begin
        repeat (TIMEOUT) @(posedge clk);
        @(negedge clk);
        chk("stop_before_timeout", eng_stop, 0);
        @(posedge clk); @(negedge clk);
        e_err = 2;
        fin = 1'b1;
      end else begin
        repeat (dly[b]) @(posedge clk);
        @(negedge clk);
        eng_byte_done = 1'b1;
        eng_nack = (act[b] == 1);
        @(posedge clk); @(negedge clk);
        eng_byte_done = 1'b0;
        eng_nack = 1'b0;
        if (act[b] == 1) begin
          e_err = 1;
          fin = 1'b1;
        end else if (b == 2) begin
          fin = 1'b1;
        end
      end
    end
    chk("eng_stop", eng_stop, 1);
    chk("no_load_at_stop", eng_load, 0);
    chk("no_early_done", done, 0);
    eng_idle = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("done", done, 1 << w);
    chk("err", err, e_err);
    chk("gnt_fin", gnt, 1 << w);
    chk("stop_one_cycle", eng_stop, 0);
    rr_m = w;
    req = '0;
    @(posedge clk); @(negedge clk);
    chk("gnt_release", gnt, 0);
    chk("done_one_cycle", done, 0);
    chk("busy_idle", busy, 0);
    chk("err_hold", err, e_err);
  endtask

  task automatic rand_fields();
    req_dev = 28'($urandom);
    req_reg = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic set_acts(input int a0, input int a1, input int a2,
                          input int d0, input int d1, input int d2);
    act[0] = a0; act[1] = a1; act[2] = a2;
    dly[0] = d0; dly[1] = d1; dly[2] = d2;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_dev = '0;
    req_reg = '0;
    req_wdata = '0;
    eng_byte_done = 1'b0;
    eng_nack = 1'b0;
    eng_idle = 1'b1;
    rr_m = NREQ - 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_load", eng_load, 0);
    chk("rst_stop", eng_stop, 0);
    chk("rst_err", err, 0);
    chk("rst_data", eng_data, 0);
    rst = 1'b0;

    // Basic write to client 0, 20-cycle ACKs.
    rand_fields();
    req_dev[6:0] = 7'h50;
    req_reg[7:0] = 8'h10;
    req_wdata[7:0] = 8'hA5;
    set_acts(0, 0, 0, 20, 20, 20);
    run_txn(4'b0001, 1'b0);

    // All clients requesting: strict rotation.
    for (int i = 0; i < 8; i++) begin
      rand_fields();
      set_acts(0, 0, 0, $urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6));
      run_txn(4'hF, 1'b0);
    end

    // NACK on the register byte.
    rand_fields();
    set_acts(0, 1, 0, 3, 4, 3);
    run_txn(4'b0100, 1'b0);

    // No response at all on the first byte.
    rand_fields();
    set_acts(2, 0, 0, 1, 1, 1);
    run_txn(4'b1000, 1'b0);

    // ACK arriving exactly in the timeout cycle.
    rand_fields();
    set_acts(0, 0, 0, TIMEOUT, 2, TIMEOUT);
    run_txn(4'b0010, 1'b0);

    // Client drops req and rewrites its fields after the grant.
    rand_fields();
    set_acts(0, 0, 0, 5, 5, 5);
    run_txn(4'b0110, 1'b1);

    // Reset in the middle of byte 1.
    rand_fields();
    eng_idle = 1'b1;
    req = 4'b0100;
    @(posedge clk); @(negedge clk);
    chk("rst_txn_busy", busy, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    eng_byte_done = 1'b1;
    @(posedge clk); @(negedge clk);
    eng_byte_done = 1'b0;
    chk("rst_txn_load1", eng_load, 1);
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_load", eng_load, 0);
    chk("midrst_stop", eng_stop, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    req = '0;
    rr_m = NREQ - 1;
    @(posedge clk); @(negedge clk);
    chk("postrst_done", done, 0);
    chk("postrst_err", err, 0);
    set_acts(0, 0, 0, 2, 2, 2);
    run_txn(4'hF, 1'b0);

    // Randomized mix.
    for (int i = 0; i < 40; i++) begin
      int r;
      rand_fields();
      for (int b = 0; b < 3; b++) begin
        r = $urandom_range(0, 19);
        act[b] = (r < 15) ? 0 : (r < 19) ? 1 : 2;
        dly[b] = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(1, 25);
      end
      run_txn(4'($urandom_range(1, 15)), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
